pdpu_chunk_sched: RTL
=====================

// Module: pdpu_chunk_sched
// PURPOSE
//  Job sequencer in front of the N-lane posit dot-product datapath. Accepts one job
//  (vector length L), splits it into ceil(L/N) lane-beats with per-lane enable masks,
//  marks the first/last beat for accumulator clear/commit, waits out the fixed pipeline
//  latency, then reports completion. Jobs are strictly serial; no overlap.
// PARAMETERS
//  N         4    lanes per beat; power of two, >=1
//  MAX_LEN   256  max elements per job; longer requests clamp
//  PIPE_LAT  3    datapath cycles from beat accept to result valid; >=0
//  LEN_W     cf_math_pkg::idx_width(MAX_LEN+1)                 job length width
//  CNT_W     cf_math_pkg::idx_width(cf_math_pkg::ceil_div(MAX_LEN,N)+1)  beat index/count width
// PORTS
//  clk_i          in   1      clock, all state on rising edge
//  rst_ni         in   1      asynchronous reset, active low
//  abort_i        in   1      synchronous abort of current job
//  job_valid_i    in   1      job request
//  job_ready_o    out  1      job accepted when valid&ready
//  job_len_i      in   LEN_W  element count L
//  beat_valid_o   out  1      beat offered to datapath
//  beat_ready_i   in   1      datapath accepts beat
//  beat_idx_o     out  CNT_W  beat index 0..B-1 (operand base = idx*N)
//  beat_mask_o    out  N      lane k enabled iff idx*N+k < L
//  beat_first_o   out  1      idx==0 (clear accumulator)
//  beat_last_o    out  1      idx==B-1 (commit accumulator)
//  done_valid_o   out  1      job result ready
//  done_ready_i   in   1      completion consumed
//  done_beats_o   out  CNT_W  beats issued B
//  done_empty_o   out  1      L was 0, no beats issued
//  done_err_o     out  1      L exceeded MAX_LEN, clamped
//  busy_o         out  1      state != IDLE
// BEHAVIOUR
//  - Reset (rst_ni=0, async): state IDLE, counters 0, flags 0; all outputs 0 except
//    job_ready_o=1.
//  - Leff = min(L,MAX_LEN); B = (Leff+N-1)>>log2(N); latched on accept; err = L>MAX_LEN.
//  - FSM IDLE->ISSUE->DRAIN->DONE->IDLE:
//    IDLE : job_ready_o=1. On accept: Leff>0 -> ISSUE with idx=0; Leff==0 -> DONE,
//           empty=1, B=0.
//    ISSUE: beat_valid_o=1; idx/mask/first/last held stable until beat_ready_i.
//           On handshake: not last -> idx+1; last -> DRAIN with cnt=PIPE_LAT,
//           or DONE directly if PIPE_LAT==0.
//    DRAIN: cnt decrements each cycle; cnt==1 -> DONE. done_valid_o therefore rises
//           exactly PIPE_LAT cycles after the last-beat handshake edge.
//    DONE : done_valid_o=1, done_* stable until done_ready_i; on handshake -> IDLE.
//  - Last-beat mask: (Leff mod N)==0 -> all ones, else low (Leff mod N) bits set.
//  - beat_* and done_* outputs are 0 whenever their valid is 0.
//  - abort_i high at a clock edge: any state -> IDLE, no done pulse; beats already
//    accepted are the datapath's problem. abort_i wins over every simultaneous handshake,
//    including a job accept in IDLE.
//  - One job in flight: job_ready_o=0 outside IDLE, even in the DONE handshake cycle.
//    The next job can be accepted the cycle after IDLE is entered.
//  - Reset mid-job discards everything; no partial done.
// TESTING  (N=4, MAX_LEN=256, PIPE_LAT=3)
//  - L=10, ready=1: beats idx0/1/2, masks 1111/1111/0011, first@0, last@2; done_valid_o
//    3 cycles after last handshake, done_beats_o=3.
//  - L=8, beat_ready_i low 5 cycles at idx1: idx=1, mask=1111 stable throughout;
//    B=2; done_err_o=0.
//  - L=1 -> single beat mask 0001, first=last=1; L=0 -> no beat_valid, done_valid_o next
//    cycle, done_empty_o=1, done_beats_o=0.
//  - L=300 -> clamped: 64 beats, last mask 1111, done_err_o=1.
//  - abort_i in DRAIN cycle 2 -> IDLE next cycle, no done_valid_o; next job L=4 runs
//    normally.
//  - rst_ni low mid-ISSUE -> outputs 0 immediately, job_ready_o=1;
//    done_ready_i held low 10 cycles holds done_* stable.

Source files
------------

// File: rtl/pdpu_chunk_sched.sv
// pdpu_chunk_sched
// Job sequencer in front of the N-lane posit dot-product datapath. A job of
// length L is cut into ceil(min(L,MAX_LEN)/N) beats. Each beat carries a lane
// mask, first/last flags (accumulator clear/commit) and its index. After the
// last beat the block waits out the datapath latency and then reports
// completion. Only one job is in flight at a time.
//
// Ports
//   clk_i, rst_ni              clock, async active-low reset
//   abort_i                    synchronous abort, overrides every handshake
//   job_valid_i/job_ready_o    job request handshake, job_len_i = L
//   beat_*                     beat stream to the datapath (valid/ready)
//   done_*                     completion record (valid/ready)
//   busy_o                     a job is in progress (state != IDLE)
//
// state  | meaning
// IDLE   | waiting for a job, job_ready_o high
// ISSUE  | offering beat idx_q to the datapath
// DRAIN  | last beat accepted, counting down the pipeline latency
// DONE   | completion record offered until done_ready_i

module pdpu_chunk_sched #(
  parameter int N        = 4,
  parameter int MAX_LEN  = 256,
  parameter int PIPE_LAT = 3,
  parameter int LEN_W    = ((MAX_LEN + 1) > 1) ? $clog2(MAX_LEN + 1) : 1,
  parameter int CNT_W    = (((MAX_LEN + N - 1) / N + 1) > 1) ?
                           $clog2((MAX_LEN + N - 1) / N + 1) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             abort_i,
  input  logic             job_valid_i,
  output logic             job_ready_o,
  input  logic [LEN_W-1:0] job_len_i,
  output logic             beat_valid_o,
  input  logic             beat_ready_i,
  output logic [CNT_W-1:0] beat_idx_o,
  output logic [N-1:0]     beat_mask_o,
  output logic             beat_first_o,
  output logic             beat_last_o,
  output logic             done_valid_o,
  input  logic             done_ready_i,
  output logic [CNT_W-1:0] done_beats_o,
  output logic             done_empty_o,
  output logic             done_err_o,
  output logic             busy_o
);

  localparam int LOG2N  = $clog2(N);
  localparam int PCNT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [CNT_W-1:0]    beats_q, beats_d;
  logic [CNT_W-1:0]    idx_q, idx_d;
  logic [PCNT_W-1:0]   cnt_q, cnt_d;
  logic                empty_q, empty_d;
  logic                err_q, err_d;

  logic                len_over;
  logic [LEN_W-1:0]    len_eff;
  logic [LEN_W:0]      len_round;
  logic                is_last;
  logic [N-1:0]        mask;

  // Clamp and beat count are computed from the live request; only latched on accept.
  assign len_over  = job_len_i > LEN_W'(MAX_LEN);
  assign len_eff   = len_over ? LEN_W'(MAX_LEN) : job_len_i;
  assign len_round = {1'b0, len_eff} + (LEN_W + 1)'(N - 1);

  assign is_last = (idx_q == beats_q - CNT_W'(1));

  // Lane k live iff idx*N + k < Leff; covers both full beats and the short tail.
  always_comb begin
    logic [31:0] base;
    mask = '0;
    base = 32'(idx_q) << LOG2N;
    for (int k = 0; k < N; k++) begin
      mask[k] = (base + 32'(k)) < 32'(len_q);
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    beats_d = beats_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    empty_d = empty_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (job_valid_i) begin
          len_d   = len_eff;
          beats_d = CNT_W'(len_round >> LOG2N);
          err_d   = len_over;
          idx_d   = '0;
          if (len_eff == '0) begin
            empty_d = 1'b1;
            state_d = DONE;
          end else begin
            empty_d = 1'b0;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (beat_ready_i) begin
          if (!is_last) begin
            idx_d = idx_q + CNT_W'(1);
          end else if (PIPE_LAT == 0) begin
            state_d = DONE;
          end else begin
            cnt_d   = PCNT_W'(PIPE_LAT);
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (cnt_q <= PCNT_W'(1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - PCNT_W'(1);
        end
      end
      DONE: begin
        if (done_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort beats any handshake in the same cycle, including a job accept.
    if (abort_i) begin
      state_d = IDLE;
      len_d   = len_q;
      beats_d = beats_q;
      idx_d   = idx_q;
      cnt_d   = '0;
      empty_d = empty_q;
      err_d   = err_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      len_q   <= '0;
      beats_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      beats_q <= beats_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      empty_q <= empty_d;
      err_q   <= err_d;
    end
  end

  // Payloads are gated by their valid so downstream never sees stale data.
  always_comb begin
    job_ready_o  = (state_q == IDLE);
    busy_o       = (state_q != IDLE);
    beat_valid_o = (state_q == ISSUE);
    beat_idx_o   = beat_valid_o ? idx_q : '0;
    beat_mask_o  = beat_valid_o ? mask : '0;
    beat_first_o = beat_valid_o && (idx_q == '0);
    beat_last_o  = beat_valid_o && is_last;
    done_valid_o = (state_q == DONE);
    done_beats_o = done_valid_o ? beats_q : '0;
    done_empty_o = done_valid_o && empty_q;
    done_err_o   = done_valid_o && err_q;
  end

endmodule
